// File: rtl/hazard_ctrl.sv
// Hazard and sequencing control for the 5-stage RV32 pipeline: operand forwarding, load-use and
// branch-in-Decode stalls, multi-cycle mul/div sequencing with a watchdog, and stall/flush counters.
module hazard_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcE,
    input  logic [1:0]       ResultSrcM,
    input  logic             BranchD,
    input  logic             PCSrcD,
    input  logic             MDStartE,
    input  logic             MDDoneE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             MDBusy,
    output logic             MDTimeoutErr,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam int            MDC_W    = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [MDC_W-1:0] MDC_LAST = MDC_W'(MD_TIMEOUT - 1);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    state_t           state;
    logic [MDC_W-1:0] md_cnt;
    logic             lw_stall;
    logic             br_stall;
    logic             hz_stall;

    // Memory stage wins over Writeback because it holds the younger value.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                           input logic [4:0] rd_w, input logic we_m,
                                           input logic we_w);
        if (we_m && rd_m != 5'd0 && rd_m == rs)
            return 2'b10;
        else if (we_w && rd_w != 5'd0 && rd_w == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign MDBusy = (state == MD_BUSY);

    always_comb begin
        lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
        br_stall = BranchD &&
                   ((RegWriteE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D)) ||
                    (ResultSrcM == 2'b01 && RdM != 5'd0 && (RdM == Rs1D || RdM == Rs2D)));
        hz_stall = lw_stall || br_stall;
    end

    // All control pins are held inactive while reset is asserted.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        if (!rst) begin
            ForwardAE = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
            ForwardBE = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);
            ForwardAD = RegWriteM && (RdM != 5'd0) && (RdM == Rs1D);
            ForwardBD = RegWriteM && (RdM != 5'd0) && (RdM == Rs2D);
            if (state == MD_BUSY) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else begin
                StallF = hz_stall;
                StallD = hz_stall;
                FlushE = hz_stall;
                // A taken decision made on stale operands must not redirect fetch.
                FlushD = PCSrcD && !hz_stall;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            md_cnt       <= '0;
            MDTimeoutErr <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (MDStartE && !MDDoneE) begin
                        state  <= MD_BUSY;
                        md_cnt <= '0;
                    end
                end
                MD_BUSY: begin
                    md_cnt <= md_cnt + MDC_W'(1);
                    if (MDDoneE) begin
                        state <= RUN;
                    end else if (md_cnt == MDC_LAST) begin
                        state        <= RUN;
                        MDTimeoutErr <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallF)
                StallCnt <= sat_inc(StallCnt);
            if (FlushD || FlushE)
                FlushCnt <= sat_inc(FlushCnt);
        end
    end

endmodule
